// File: rtl/dmem_bridge_pkg.sv
// Shared definitions for the data-memory bridge.
//   DATA_W      : CPU/bus data width
//   SZ_*        : access size encodings (2'b11 is folded onto word)
//   state_e     : bridge FSM states
//   norm_size() : maps the reserved size code onto word
package dmem_bridge_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == 2'b11) ? SZ_WORD : s;
  endfunction

endpackage

// File: rtl/dmem_bridge_if.sv
// SRAM-like split-handshake data bus.
//   master (bridge): req, wr, size, addr, wdata, wstrb out; addr_ok, data_ok, rdata in
//   slave  (memory): the reverse directions
interface dmem_bridge_if #(
  parameter int unsigned ADDR_W = 32
);
  import dmem_bridge_pkg::*;

  logic              req;
  logic              wr;
  logic [1:0]        size;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic              addr_ok;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, wr, size, addr, wdata, wstrb,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata, wstrb,
    output addr_ok, data_ok, rdata
  );

endinterface

// File: rtl/dmem_bridge_mem_lane.sv
// Byte-lane steering for the data-memory bridge (purely combinational).
//   addr_lo   : address bits [1:0]
//   size      : normalised access size
//   sign      : sign-extend byte/half loads
//   is_store  : strobes are zero for loads
//   wdata_in  : right-aligned store data  -> wdata_out : lane-replicated store data
//   rdata_in  : raw bus read data         -> rdata_out : extracted, extended load data
//   wstrb     : byte strobes
module dmem_bridge_mem_lane
  import dmem_bridge_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic              sign,
  input  logic              is_store,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] rdata_in,
  output logic [3:0]        wstrb,
  output logic [DATA_W-1:0] wdata_out,
  output logic [DATA_W-1:0] rdata_out
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    case (addr_lo)
      2'd0:    rd_byte = rdata_in[7:0];
      2'd1:    rd_byte = rdata_in[15:8];
      2'd2:    rd_byte = rdata_in[23:16];
      default: rd_byte = rdata_in[31:24];
    endcase
    rd_half = addr_lo[1] ? rdata_in[31:16] : rdata_in[15:0];
  end

  always_comb begin
    wstrb     = '0;
    wdata_out = wdata_in;
    rdata_out = rdata_in;
    case (size)
      SZ_BYTE: begin
        wstrb     = 4'b0001 << addr_lo;
        wdata_out = {4{wdata_in[7:0]}};
        rdata_out = {{24{sign & rd_byte[7]}}, rd_byte};
      end
      SZ_HALF: begin
        wstrb     = 4'b0011 << addr_lo;
        wdata_out = {2{wdata_in[15:0]}};
        rdata_out = {{16{sign & rd_half[15]}}, rd_half};
      end
      default: begin
        wstrb     = 4'b1111;
        wdata_out = wdata_in;
        rdata_out = rdata_in;
      end
    endcase
    if (!is_store) begin
      wstrb = '0;
    end
  end

endmodule

// File: rtl/dmem_bridge.sv
// Memory-stage bridge: turns one M-stage request into one split-handshake
// bus transaction, stalls the pipeline meanwhile and returns load data.
//   clk, rst         : clock, asynchronous active-low reset
//   memenM/memwriteM : access valid / store
//   sizeM, loadsignM : access size, sign-extend loads
//   addrM, wdataM    : effective address, right-aligned store data
//   flushM, advM     : M stage killed / M stage advances
//   rdataM           : extended load result (registered)
//   stallM           : memory stall request
//   adelM/adesM      : misaligned load / store (combinational)
//   bus              : master side of the data bus
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memenM,
  input  logic              memwriteM,
  input  logic [1:0]        sizeM,
  input  logic              loadsignM,
  input  logic [ADDR_W-1:0] addrM,
  input  logic [DATA_W-1:0] wdataM,
  input  logic              flushM,
  input  logic              advM,
  output logic [DATA_W-1:0] rdataM,
  output logic              stallM,
  output logic              adelM,
  output logic              adesM,
  dmem_bridge_if.master     bus
);

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic              wr_q, wr_d;
  logic [1:0]        size_q, size_d;
  logic              sign_q, sign_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cancel_q, cancel_d;

  logic [1:0]        size_n;
  logic              misaligned;
  logic              new_req;
  logic              cancel_now;
  logic              stall_c;
  logic              in_idle;
  logic [3:0]        lane_wstrb;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;

  assign size_n     = norm_size(sizeM);
  assign misaligned = ((size_n == SZ_HALF) && addrM[0]) ||
                      ((size_n == SZ_WORD) && (addrM[1:0] != 2'b00));
  assign adelM      = memenM & ~memwriteM & misaligned;
  assign adesM      = memenM &  memwriteM & misaligned;
  assign new_req    = memenM & ~flushM & ~misaligned;
  assign cancel_now = cancel_q | flushM;
  assign in_idle    = (state_q == ST_IDLE);

  // One lane block serves both directions: at issue it steers store data
  // from the live M-stage inputs, afterwards it extracts load data using
  // the request fields latched at issue.
  dmem_bridge_mem_lane u_lane (
    .addr_lo   (in_idle ? addrM[1:0] : addr_q[1:0]),
    .size      (in_idle ? size_n : size_q),
    .sign      (sign_q),
    .is_store  (memwriteM),
    .wdata_in  (wdataM),
    .rdata_in  (bus.rdata),
    .wstrb     (lane_wstrb),
    .wdata_out (lane_wdata),
    .rdata_out (lane_rdata)
  );

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    wr_d     = wr_q;
    size_d   = size_q;
    sign_d   = sign_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wstrb_d  = wstrb_q;
    rdata_d  = rdata_q;
    cancel_d = cancel_q;
    stall_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cancel_d = 1'b0;
        if (new_req) begin
          stall_c = 1'b1;
          req_d   = 1'b1;
          wr_d    = memwriteM;
          size_d  = size_n;
          sign_d  = loadsignM;
          addr_d  = addrM;
          wdata_d = lane_wdata;
          wstrb_d = lane_wstrb;
          state_d = ST_REQ;
        end
      end
      ST_REQ, ST_WAIT: begin
        // Once cancelled, the stall only reflects a new request that has
        // to wait for the committed transaction to drain.
        stall_c = cancel_now ? new_req : 1'b1;
        if (flushM) begin
          cancel_d = 1'b1;
        end
        if ((state_q == ST_REQ) && bus.addr_ok) begin
          req_d   = 1'b0;
          state_d = ST_WAIT;
        end
        if (bus.data_ok && ((state_q == ST_WAIT) || bus.addr_ok)) begin
          if (cancel_now) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DONE;
            if (!wr_q) begin
              rdata_d = lane_rdata;
            end
          end
        end
      end
      ST_DONE: begin
        if (flushM || advM) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      req_q    <= 1'b0;
      wr_q     <= 1'b0;
      size_q   <= '0;
      sign_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      cancel_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      sign_q   <= sign_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wstrb_q  <= wstrb_d;
      rdata_q  <= rdata_d;
      cancel_q <= cancel_d;
    end
  end

  // Gated so the stall also reads zero while reset is held with memenM high.
  assign stallM    = stall_c & rst;
  assign rdataM    = rdata_q;
  assign bus.req   = req_q;
  assign bus.wr    = wr_q;
  assign bus.size  = size_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.wstrb = wstrb_q;

endmodule

// File: tb/tb_dmem_bridge.sv
module tb_dmem_bridge;
  import dmem_bridge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        memenM, memwriteM, loadsignM, flushM, advM;
  logic [1:0]  sizeM;
  logic [31:0] addrM, wdataM;
  logic [31:0] rdataM;
  logic        stallM, adelM, adesM;

  always #5 clk = ~clk;

  dmem_bridge_if #(.ADDR_W(32)) bus_if ();

  dmem_bridge #(.ADDR_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .memenM    (memenM),
    .memwriteM (memwriteM),
    .sizeM     (sizeM),
    .loadsignM (loadsignM),
    .addrM     (addrM),
    .wdataM    (wdataM),
    .flushM    (flushM),
    .advM      (advM),
    .rdataM    (rdataM),
    .stallM    (stallM),
    .adelM     (adelM),
    .adesM     (adesM),
    .bus       (bus_if)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  bit          chk_on = 1'b0;
  bit          exp_stall, exp_req;
  logic [31:0] exp_rdataM;
  logic        exp_wr;
  logic [1:0]  exp_size;
  logic [31:0] exp_addr, exp_wdata;
  logic [3:0]  exp_wstrb;

  logic        last_wr;
  logic [1:0]  last_size;
  logic [31:0] last_wdata;
  logic [3:0]  last_wstrb;
  logic        prev_req = 1'b0;
  int unsigned req_rises = 0;
  int unsigned stall_cnt = 0;

  // ---------------- reference model (plain arithmetic) ----------------
  function automatic logic [1:0] f_norm(input logic [1:0] sz);
    return (sz == 2'd3) ? 2'd2 : sz;
  endfunction

  function automatic int unsigned f_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit f_mis(input logic [1:0] sz, input logic [31:0] a);
    return (a % f_bytes(f_norm(sz))) != 0;
  endfunction

  function automatic logic [3:0] f_strb(input bit w, input logic [1:0] sz, input logic [31:0] a);
    int unsigned m;
    if (!w) return 4'd0;
    m = ((32'd1 << f_bytes(sz)) - 1) << (a % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] f_wdata(input logic [1:0] sz, input logic [31:0] w);
    case (f_bytes(sz))
      1:       return (w % 256) * 32'h0101_0101;
      2:       return (w % 65536) * 32'h0001_0001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] sz, input bit sg, input logic [31:0] a,
                                         input logic [31:0] rd);
    int unsigned nb;
    logic [31:0] v, span;
    nb = f_bytes(sz);
    if (nb == 4) return rd;
    span = 32'd1 << (8 * nb);
    v = (rd >> (8 * (a % 4))) % span;
    if (sg && (v >= span / 2)) v = v - span;
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check32("adelM", {31'd0, adelM},
              {31'd0, memenM && !memwriteM && f_mis(sizeM, addrM)});
      check32("adesM", {31'd0, adesM},
              {31'd0, memenM && memwriteM && f_mis(sizeM, addrM)});
      check32("stallM", {31'd0, stallM}, {31'd0, exp_stall});
      check32("req", {31'd0, bus_if.req}, {31'd0, exp_req});
      check32("rdataM", rdataM, exp_rdataM);
      if (bus_if.req) begin
        check32("bus_wr", {31'd0, bus_if.wr}, {31'd0, exp_wr});
        check32("bus_size", {30'd0, bus_if.size}, {30'd0, exp_size});
        check32("bus_addr", bus_if.addr, exp_addr);
        check32("bus_wdata", bus_if.wdata, exp_wdata);
        check32("bus_wstrb", {28'd0, bus_if.wstrb}, {28'd0, exp_wstrb});
        last_wr    = bus_if.wr;
        last_size  = bus_if.size;
        last_wdata = bus_if.wdata;
        last_wstrb = bus_if.wstrb;
        if (!prev_req) req_rises++;
      end
      if (stallM) stall_cnt++;
    end
    prev_req = bus_if.req;
  end

  // ---------------- stimulus ----------------
  task automatic step(input bit s, input bit r);
    exp_stall = s;
    exp_req   = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check32({tag, "_req"}, {31'd0, bus_if.req}, 32'd0);
    check32({tag, "_wr"}, {31'd0, bus_if.wr}, 32'd0);
    check32({tag, "_size"}, {30'd0, bus_if.size}, 32'd0);
    check32({tag, "_addr"}, bus_if.addr, 32'd0);
    check32({tag, "_wdata"}, bus_if.wdata, 32'd0);
    check32({tag, "_wstrb"}, {28'd0, bus_if.wstrb}, 32'd0);
    check32({tag, "_rdataM"}, rdataM, 32'd0);
    check32({tag, "_stallM"}, {31'd0, stallM}, 32'd0);
  endtask

  task automatic set_bus(input bit aok, input bit dok, input logic [31:0] rd);
    bus_if.addr_ok = aok;
    bus_if.data_ok = dok;
    bus_if.rdata   = rd;
  endtask

  // One aligned or misaligned access: alat idle REQ cycles before addr_ok,
  // data_ok dlat cycles after addr_ok, hold DONE cycles, then advM or flushM.
  task automatic access(input bit w, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rd, input int unsigned alat,
                        input int unsigned dlat, input int unsigned hold, input bit fl_done);
    logic [1:0] szn;
    szn = f_norm(sz);
    memenM = 1'b1; memwriteM = w; sizeM = sz; loadsignM = sg; addrM = a; wdataM = wd;
    flushM = 1'b0; advM = 1'b0;
    set_bus(1'b0, 1'b0, ~rd);
    if (f_mis(sz, a)) begin
      step(1'b0, 1'b0);
      memenM = 1'b0;
      return;
    end
    exp_wr    = w;
    exp_size  = szn;
    exp_addr  = a;
    exp_wdata = f_wdata(szn, wd);
    exp_wstrb = f_strb(w, szn, a);
    step(1'b1, 1'b0);
    for (int unsigned i = 0; i <= alat; i++) begin
      if (i == alat && dlat == 0) set_bus(1'b1, 1'b1, rd);
      else set_bus(i == alat, 1'b0, ~rd);
      step(1'b1, 1'b1);
    end
    for (int unsigned j = 1; j <= dlat; j++) begin
      if (j == dlat) set_bus(1'b0, 1'b1, rd);
      else set_bus(1'b0, 1'b0, ~rd);
      step(1'b1, 1'b0);
    end
    set_bus(1'b0, 1'b0, ~rd);
    if (!w) exp_rdataM = f_load(szn, sg, a, rd);
    for (int unsigned h = 0; h < hold; h++) step(1'b0, 1'b0);
    if (fl_done) flushM = 1'b1;
    else advM = 1'b1;
    step(1'b0, 1'b0);
    memenM = 1'b0; flushM = 1'b0; advM = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    memenM = 1'b0; memwriteM = 1'b0; sizeM = 2'd0; loadsignM = 1'b0;
    addrM = '0; wdataM = '0; flushM = 1'b0; advM = 1'b0;
    set_bus(1'b0, 1'b0, '0);
    exp_stall = 1'b0; exp_req = 1'b0; exp_rdataM = '0;
    exp_wr = 1'b0; exp_size = '0; exp_addr = '0; exp_wdata = '0; exp_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_on = 1'b1;

    // word load, addr_ok in first REQ cycle, data_ok one cycle later
    stall_cnt = 0; req_rises = 0;
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1, 2, 1'b0);
    check32("lw100_rdataM", rdataM, 32'hDEAD_BEEF);
    check32("lw100_stall_cycles", stall_cnt, 32'd3);
    check32("lw100_req_pulses", req_rises, 32'd1);

    // minimum latency, back to back with the previous access
    stall_cnt = 0; req_rises = 0;
    access(1'b0, 2'd2, 1'b0, 32'h104, 32'h0, 32'h1122_3344, 0, 0, 1, 1'b0);
    check32("lw104_rdataM", rdataM, 32'h1122_3344);
    check32("lw104_stall_cycles", stall_cnt, 32'd2);

    // sb at 0x203
    access(1'b1, 2'd0, 1'b0, 32'h203, 32'h0000_00A5, 32'h0, 1, 2, 0, 1'b0);
    check32("sb203_wstrb", {28'd0, last_wstrb}, 32'h8);
    check32("sb203_wdata", last_wdata, 32'hA5A5_A5A5);
    check32("sb203_wr", {31'd0, last_wr}, 32'd1);
    check32("sb203_size", {30'd0, last_size}, 32'd0);

    // lb / lbu at 0x201
    access(1'b0, 2'd0, 1'b1, 32'h201, 32'h0, 32'h0000_8000, 0, 1, 0, 1'b0);
    check32("lb201_rdataM", rdataM, 32'hFFFF_FF80);
    access(1'b0, 2'd0, 1'b0, 32'h201, 32'h0, 32'h0000_8000, 0, 1, 0, 1'b0);
    check32("lbu201_rdataM", rdataM, 32'h0000_0080);

    // halves, store half, word store with reserved size code
    access(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 32'h8001_0000, 2, 0, 1, 1'b0);
    check32("lh202_rdataM", rdataM, 32'hFFFF_8001);
    access(1'b0, 2'd1, 1'b0, 32'h206, 32'h0, 32'h8001_0000, 0, 3, 0, 1'b0);
    check32("lhu206_rdataM", rdataM, 32'h0000_8001);
    access(1'b1, 2'd1, 1'b0, 32'h206, 32'h0000_1234, 32'h0, 0, 1, 0, 1'b0);
    check32("sh206_wstrb", {28'd0, last_wstrb}, 32'hC);
    check32("sh206_wdata", last_wdata, 32'h1234_1234);
    access(1'b1, 2'd3, 1'b0, 32'h108, 32'hCAFE_F00D, 32'h0, 0, 0, 0, 1'b0);
    check32("sw108_size", {30'd0, last_size}, 32'd2);
    check32("sw108_wstrb", {28'd0, last_wstrb}, 32'hF);

    // misaligned accesses never reach the bus
    req_rises = 0;
    memenM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; addrM = 32'h102; flushM = 1'b0; advM = 1'b0;
    #1;
    check32("lw102_adelM", {31'd0, adelM}, 32'd1);
    step(1'b0, 1'b0);
    memwriteM = 1'b1; sizeM = 2'd1; addrM = 32'h101; wdataM = 32'h5555;
    #1;
    check32("sh101_adesM", {31'd0, adesM}, 32'd1);
    step(1'b0, 1'b0);
    memenM = 1'b0;
    step(1'b0, 1'b0);
    check32("misaligned_req_pulses", req_rises, 32'd0);

    // flush in REQ with addr_ok delayed 3 cycles; a new load waits for the drain
    memenM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; loadsignM = 1'b0; addrM = 32'h300; wdataM = '0;
    exp_wr = 1'b0; exp_size = 2'd2; exp_addr = 32'h300; exp_wdata = 32'h0; exp_wstrb = 4'h0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    memenM = 1'b0; flushM = 1'b1;
    step(1'b0, 1'b1);
    flushM = 1'b0; memenM = 1'b1; addrM = 32'h400;
    step(1'b1, 1'b1);
    set_bus(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1);
    set_bus(1'b0, 1'b1, 32'h1234_5678);
    step(1'b1, 1'b0);
    check32("flush_rdataM_kept", rdataM, 32'h0000_8001);
    access(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 32'h4444_0000, 0, 1, 0, 1'b0);
    check32("lw400_rdataM", rdataM, 32'h4444_0000);

    // flush in DONE, then the next access issues right away
    access(1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'h0BAD_F00D, 0, 0, 1, 1'b1);
    access(1'b0, 2'd0, 1'b1, 32'h507, 32'h0, 32'h7F00_0000, 1, 1, 0, 1'b0);
    check32("lb507_rdataM", rdataM, 32'h0000_007F);

    // reset asserted while in WAIT
    memenM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; addrM = 32'h600;
    exp_wr = 1'b0; exp_size = 2'd2; exp_addr = 32'h600; exp_wdata = 32'h0; exp_wstrb = 4'h0;
    step(1'b1, 1'b0);
    set_bus(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1);
    set_bus(1'b0, 1'b0, 32'h0);
    chk_on = 1'b0;
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    memenM = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    exp_rdataM = '0;
    @(posedge clk);
    #1;
    chk_on = 1'b1;
    step(1'b0, 1'b0);
    req_rises = 0;
    access(1'b0, 2'd2, 1'b0, 32'h604, 32'h0, 32'h600D_600D, 1, 1, 1, 1'b0);
    check32("lw604_rdataM", rdataM, 32'h600D_600D);
    check32("lw604_req_pulses", req_rises, 32'd1);

    step(1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
